// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result reader: capture-FSM state codes,
// the default sample width and the buffer entry layout.
package fft_pkg;

    localparam int unsigned FFT_DW = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Entry layout, MSB first: {last, idx, re, im}
    function automatic int unsigned entry_w(input int unsigned idx_w, input int unsigned dw);
        return 1 + idx_w + 2 * dw;
    endfunction

endpackage

// File: rtl/fft_commit_fifo.sv
// Circular buffer with write/commit/read pointers, rollback of uncommitted
// writes, and a first-word-fall-through output register.
module fft_commit_fifo
    import fft_pkg::*;
#(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned EW    = entry_w(10, FFT_DW)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [EW-1:0]            wr_data,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [EW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   free_next
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] wr_ptr_next, commit_ptr_next, rd_ptr_next;
    logic          load;

    // The output register refills whenever it is empty or being drained.
    assign load = (rd_ptr != commit_ptr) && (!rd_valid || rd_ready);

    always_comb begin
        wr_ptr_next     = wr_ptr;
        commit_ptr_next = commit_ptr;
        rd_ptr_next     = rd_ptr;
        if (rollback) begin
            wr_ptr_next = commit_ptr;
        end else if (wr_en) begin
            wr_ptr_next = wr_ptr + 1'b1;
        end
        if (commit) begin
            commit_ptr_next = wr_ptr + 1'b1;
        end
        if (load) begin
            rd_ptr_next = rd_ptr + 1'b1;
        end
    end

    assign free_next = PW'(DEPTH) - (wr_ptr_next - rd_ptr_next);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            rd_ptr     <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            commit_ptr <= commit_ptr_next;
            rd_ptr     <= rd_ptr_next;
            if (load) begin
                rd_data  <= mem[rd_ptr[AW-1:0]];
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft_result_reader.sv
// Captures N-point FFT result frames, commits them atomically and replays them
// on a valid/ready stream. FFT_RESULT_READER_STATUS_EN adds frame/drop/overrun status.
module fft_result_reader
    import fft_pkg::*;
#(
    parameter int unsigned N     = 1024,
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned DW    = FFT_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fft_ready_i,
    input  logic [DW-1:0]         x0_re_i,
    input  logic [DW-1:0]         x0_im_i,
    output logic                  dl_busy_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DW-1:0]         m_re_o,
    output logic [DW-1:0]         m_im_o,
    output logic [$clog2(N)-1:0]  m_idx_o,
`ifdef FFT_RESULT_READER_STATUS_EN
    output logic [15:0]           frame_cnt_o,
    output logic [7:0]            drop_cnt_o,
    output logic                  overrun_o,
`endif
    output logic                  m_last_o
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = entry_w(IW, DW);
    localparam logic [IW-1:0] LAST_BIN = IW'(N - 1);

    logic [1:0]    state, state_next;
    logic [IW-1:0] bin_cnt, wr_idx;
    logic          wr_en, commit, rollback, enter_discard;
    logic [EW-1:0] wr_data, rd_data;
    logic [PW-1:0] free_next;

    always_comb begin
        state_next    = state;
        wr_en         = 1'b0;
        commit        = 1'b0;
        rollback      = 1'b0;
        enter_discard = 1'b0;
        wr_idx        = bin_cnt;
        case (state)
            ST_IDLE: begin
                if (fft_ready_i) begin
                    if (!dl_busy_o) begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        state_next = ST_CAPTURE;
                    end else begin
                        enter_discard = 1'b1;
                        state_next    = ST_DISCARD;
                    end
                end
            end
            ST_CAPTURE: begin
                if (fft_ready_i) begin
                    wr_en = 1'b1;
                    if (bin_cnt == LAST_BIN) begin
                        commit     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    rollback   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (!fft_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign wr_data = {(wr_idx == LAST_BIN), wr_idx, x0_re_i, x0_im_i};

    // Busy looks at the pointers as they will be after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bin_cnt   <= '0;
            dl_busy_o <= 1'b1;
        end else begin
            state <= state_next;
            if (wr_en) begin
                bin_cnt <= wr_idx + 1'b1;
            end
            dl_busy_o <= (state_next != ST_IDLE) || (free_next < PW'(N));
        end
    end

    fft_commit_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .commit    (commit),
        .rollback  (rollback),
        .rd_ready  (m_ready_i),
        .rd_valid  (m_valid_o),
        .rd_data   (rd_data),
        .free_next (free_next)
    );

    assign {m_last_o, m_idx_o, m_re_o, m_im_o} = rd_data;

`ifdef FFT_RESULT_READER_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
            overrun_o   <= 1'b0;
        end else begin
            if (commit) begin
                frame_cnt_o <= frame_cnt_o + 1'b1;
            end
            if (rollback && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + 1'b1;
            end
            if (enter_discard) begin
                overrun_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_result_reader.sv
// Self-checking bench for fft_result_reader with N=8, DEPTH=16.
module tb_fft_result_reader;
    import fft_pkg::*;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fft_ready_i = 1'b0;
    logic [DW-1:0] x0_re_i = '0;
    logic [DW-1:0] x0_im_i = '0;
    logic          dl_busy_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b0;
    logic [DW-1:0] m_re_o;
    logic [DW-1:0] m_im_o;
    logic [2:0]    m_idx_o;
    logic          m_last_o;
`ifdef FFT_RESULT_READER_STATUS_EN
    logic [15:0]   frame_cnt_o;
    logic [7:0]    drop_cnt_o;
    logic          overrun_o;
`endif

    fft_result_reader #(.N(N), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .fft_ready_i (fft_ready_i),
        .x0_re_i     (x0_re_i),
        .x0_im_i     (x0_im_i),
        .dl_busy_o   (dl_busy_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_re_o      (m_re_o),
        .m_im_o      (m_im_o),
        .m_idx_o     (m_idx_o),
`ifdef FFT_RESULT_READER_STATUS_EN
        .frame_cnt_o (frame_cnt_o),
        .drop_cnt_o  (drop_cnt_o),
        .overrun_o   (overrun_o),
`endif
        .m_last_o    (m_last_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [2:0]    idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } beat_t;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    exp_idx;
        logic          exp_last;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    beats = 0;
    int    lasts = 0;
    int    rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready_i = 1'b1;
            1:       m_ready_i = 1'b0;
            default: m_ready_i = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Scoreboard: every accepted beat must match the next expected entry,
    // and a stalled beat must stay put.
    logic        hold_chk = 1'b0;
    logic [68:0] hold_snap;
    always @(negedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk)
                chk("hold", {m_valid_o, m_last_o, m_idx_o, m_re_o, m_im_o}, hold_snap);
            if (m_valid_o && m_ready_i) begin
                beats++;
                if (m_last_o) lasts++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got idx %0d re %0h, expected no beat", m_idx_o, m_re_o);
                end else begin
                    chk("beat", {m_last_o, m_idx_o, m_re_o, m_im_o}, exp_q.pop_front());
                end
            end
            hold_chk  = m_valid_o && !m_ready_i;
            hold_snap = {m_valid_o, m_last_o, m_idx_o, m_re_o, m_im_o};
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, dl_busy_o, 1'b1);
        chk({tag, "_valid"}, m_valid_o, 1'b0);
        chk({tag, "_last"}, m_last_o, 1'b0);
        chk({tag, "_idx"}, m_idx_o, 3'd0);
        chk({tag, "_data"}, {m_re_o, m_im_o}, 64'd0);
`ifdef FFT_RESULT_READER_STATUS_EN
        chk({tag, "_status"}, {frame_cnt_o, drop_cnt_o, overrun_o}, 25'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b1;
        fft_ready_i = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_vals(tag);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_after"}, dl_busy_o, 1'b0);
    endtask

    task automatic wait_not_busy(input string tag);
        int n = 0;
        while (dl_busy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (dl_busy_o) chk({tag, "_busy_timeout"}, 1'b1, 1'b0);
    endtask

    // Model: each complete group of N consecutive strobes is a frame; only
    // frames started while accepted are ever output, partial tails never.
    task automatic send_burst(input int len, input bit accept);
        beat_t frame[N];
        for (int k = 0; k < len; k++) begin
            @(posedge clk); #1;
            fft_ready_i = 1'b1;
            x0_re_i = $urandom;
            x0_im_i = $urandom;
            frame[k % N] = {((k % N) == N - 1), 3'(k % N), x0_re_i, x0_im_i};
            if (accept && (k % N) == N - 1)
                for (int j = 0; j < N; j++) exp_q.push_back(frame[j]);
        end
        @(posedge clk); #1;
        fft_ready_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        vec_t tbl[N];
        int   c0, b0, l0;
        for (int k = 0; k < N; k++) begin
            tbl[k].re       = k;
            tbl[k].im       = -k;
            tbl[k].exp_idx  = 3'(k);
            tbl[k].exp_last = (k == N - 1);
        end

        // 1: single frame, latency, table compare
        rdy_mode = 0;
        do_reset("t1_rst");
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            if (k == 0) c0 = cyc;
            fft_ready_i = 1'b1;
            x0_re_i = tbl[k].re;
            x0_im_i = tbl[k].im;
            exp_q.push_back({tbl[k].exp_last, tbl[k].exp_idx, tbl[k].re, tbl[k].im});
        end
        @(posedge clk); #1;
        fft_ready_i = 1'b0;
        @(negedge clk);
        chk("t1_not_early", m_valid_o, 1'b0);
        for (int j = 0; j < N; j++) begin
            @(negedge clk);
            chk("t1_latency", cyc - c0, 9 + j);
            chk("t1_vec", {m_valid_o, m_last_o, m_idx_o, m_re_o, m_im_o},
                {1'b1, tbl[j].exp_last, tbl[j].exp_idx, tbl[j].re, tbl[j].im});
        end
        drain("t1");

        // 2: buffer full, overrun, release
        rdy_mode = 1;
        do_reset("t2_rst");
        send_burst(16, 1'b1);
        repeat (2) @(negedge clk);
        chk("t2_busy_full", dl_busy_o, 1'b1);
        send_burst(N, 1'b0);
`ifdef FFT_RESULT_READER_STATUS_EN
        @(negedge clk);
        chk("t2_overrun", overrun_o, 1'b1);
`endif
        b0 = beats;
        rdy_mode = 0;
        drain("t2");
        chk("t2_beats", beats - b0, 16);

        // 3: truncation then full frame
        do_reset("t3_rst");
        b0 = beats;
        send_burst(5, 1'b1);
        wait_not_busy("t3");
        send_burst(N, 1'b1);
        drain("t3");
        chk("t3_beats", beats - b0, 8);
`ifdef FFT_RESULT_READER_STATUS_EN
        chk("t3_counts", {drop_cnt_o, frame_cnt_o}, {8'd1, 16'd1});
`endif

        // 4: back-to-back frames
        do_reset("t4_rst");
        b0 = beats;
        l0 = lasts;
        send_burst(16, 1'b1);
        drain("t4");
        chk("t4_beats", beats - b0, 16);
        chk("t4_lasts", lasts - l0, 2);

        // 5: reset in the middle of a capture
        do_reset("t5_rst");
        b0 = beats;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            fft_ready_i = 1'b1;
            x0_re_i = $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("t5_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        fft_ready_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_busy_after", dl_busy_o, 1'b0);
        repeat (12) @(negedge clk);
        chk("t5_no_beats", beats - b0, 0);
        send_burst(N, 1'b1);
        drain("t5");
        chk("t5_beats", beats - b0, 8);

        // 6: random back-pressure over four frames
        do_reset("t6_rst");
        rdy_mode = 2;
        b0 = beats;
        for (int f = 0; f < 4; f++) begin
            wait_not_busy("t6");
            send_burst(N, 1'b1);
        end
        drain("t6");
        chk("t6_beats", beats - b0, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
